// File: rtl/seg_595_pkg.sv
// Purpose: shared constants, FSM encoding and frame-width helper for the 595 display driver.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package seg_595_pkg;

    // Common-anode segment codes, active-low, bit7 = dp (left dark here).
    localparam logic [7:0] SEG_LUT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_t;

    // One select bit per digit on top of the 8 segment bits.
    function automatic int frame_w(input int n_dig);
        return 8 + n_dig;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Purpose: nibble + dp + blank -> 8-bit active-low common-anode segment code.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: nibble (hex digit), dp (1 = light decimal point), blank (1 = all
// segments dark), seg (active-low code, bit7 = dp).
module hex_to_seg
    import seg_595_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : SEG_LUT[nibble];
        // A blanked digit still shows its point.
        if (dp) begin
            seg[7] = 1'b0;
        end
    end

endmodule

// File: rtl/seg_595_dynamic.sv
// Purpose: scans N_DIG hex digits through a 74HC595 chain, one serial frame per digit slot.
// Latency: stcp rises 1 + 2*SHCP_DIV*FRAME_W cycles after the LOAD cycle of each slot.
// Backpressure: none; a scan tick arriving while a frame is in flight is dropped.
// Ports: sys_clk/sys_rst_n (clock, async active-low reset); data (nibble i =
// digit i, digit 0 rightmost); point (dp per digit); seg_en (0 = blank frames);
// blank_lead (suppress leading zeros); shcp/stcp/ds (595 shift clock, latch
// clock, serial data); oe (595 output enable, active-low).
module seg_595_dynamic
    import seg_595_pkg::*;
#(
    parameter int N_DIG    = 6,
    parameter int SCAN_MAX = 50_000,
    parameter int SHCP_DIV = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [4*N_DIG-1:0]   data,
    input  logic [N_DIG-1:0]     point,
    input  logic                 seg_en,
    input  logic                 blank_lead,
    output logic                 shcp,
    output logic                 stcp,
    output logic                 ds,
    output logic                 oe
);

    localparam int FRAME_W = frame_w(N_DIG);
    localparam int SCAN_W  = $clog2(SCAN_MAX);
    localparam int DIG_W   = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int DIV_W   = $clog2(2 * SHCP_DIV);
    localparam int BIT_W   = $clog2(FRAME_W);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_MAX - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(N_DIG - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(SHCP_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * SHCP_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_TOP   = BIT_W'(FRAME_W - 1);

    state_t               state;
    state_t               state_nxt;
    logic [SCAN_W-1:0]    scan_cnt;
    logic                 scan_tick;
    logic [DIG_W-1:0]     dig_idx;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [FRAME_W-1:0]   frame;

    logic [4*N_DIG-1:0]   snap_data;
    logic [N_DIG-1:0]     snap_point;
    logic                 snap_en;
    logic                 snap_bl;

    logic [4*N_DIG-1:0]   eff_data;
    logic [N_DIG-1:0]     eff_point;
    logic                 eff_en;
    logic                 eff_bl;
    logic [3:0]           cur_nib;
    logic                 cur_dp;
    logic                 hi_zero;
    logic                 cur_blank;
    logic [N_DIG-1:0]     cur_sel;
    logic [7:0]           cur_seg;
    logic [FRAME_W-1:0]   frame_nxt;

    logic                 bit_end;
    logic                 latch_end;

    // Free-running slot timer; the tick is what starts every frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scan_cnt <= '0;
        end else if (scan_tick) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    assign scan_tick = (scan_cnt == SCAN_LAST);
    assign bit_end   = (div_cnt == DIV_LAST);
    assign latch_end = (div_cnt == DIV_HALF);

    // Digit 0 reads the live inputs in the same cycle it snapshots them, so
    // every digit of a refresh sees one consistent set of values.
    always_comb begin
        eff_data  = (dig_idx == '0) ? data       : snap_data;
        eff_point = (dig_idx == '0) ? point      : snap_point;
        eff_en    = (dig_idx == '0) ? seg_en     : snap_en;
        eff_bl    = (dig_idx == '0) ? blank_lead : snap_bl;
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        hi_zero = 1'b1;
        cur_sel = '0;
        for (int j = 0; j < N_DIG; j++) begin
            if (DIG_W'(j) == dig_idx) begin
                cur_nib    = eff_data[4*j +: 4];
                cur_dp     = eff_point[j];
                cur_sel[j] = 1'b1;
            end
            // Leading zero: this nibble and every higher one are zero.
            if ((DIG_W'(j) >= dig_idx) && (eff_data[4*j +: 4] != 4'h0)) begin
                hi_zero = 1'b0;
            end
        end
        cur_blank = !eff_en || (eff_bl && (dig_idx != '0) && hi_zero);
    end

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .blank  (cur_blank),
        .seg    (cur_seg)
    );

    assign frame_nxt = {cur_sel, cur_seg};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (scan_tick) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (bit_end && (bit_cnt == '0)) state_nxt = LATCH;
            LATCH:   if (latch_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shcp       <= 1'b0;
            stcp       <= 1'b0;
            ds         <= 1'b0;
            oe         <= 1'b1;
            dig_idx    <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            snap_data  <= '0;
            snap_point <= '0;
            snap_en    <= 1'b0;
            snap_bl    <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    frame   <= frame_nxt;
                    ds      <= frame_nxt[FRAME_W-1];
                    bit_cnt <= BIT_TOP;
                    div_cnt <= '0;
                    shcp    <= 1'b0;
                    if (dig_idx == '0) begin
                        snap_data  <= data;
                        snap_point <= point;
                        snap_en    <= seg_en;
                        snap_bl    <= blank_lead;
                    end
                end
                SHIFT: begin
                    // Low half: ds settles. High half: the 595 samples ds.
                    if (latch_end) begin
                        shcp <= 1'b1;
                    end
                    if (bit_end) begin
                        shcp    <= 1'b0;
                        div_cnt <= '0;
                        if (bit_cnt == '0) begin
                            stcp <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - BIT_W'(1);
                            ds      <= frame[bit_cnt - BIT_W'(1)];
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                LATCH: begin
                    if (latch_end) begin
                        stcp    <= 1'b0;
                        ds      <= 1'b0;
                        div_cnt <= '0;
                        // Outputs stay disabled until a real frame is latched.
                        oe      <= 1'b0;
                        dig_idx <= (dig_idx == DIG_LAST) ? '0 : dig_idx + DIG_W'(1);
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_595_dynamic.sv
// Purpose: self-checking bench for seg_595_dynamic with a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_seg_595_dynamic;

    localparam int N_DIG    = 6;
    localparam int SCAN_MAX = 100;
    localparam int SHCP_DIV = 2;
    localparam int FRAME_W  = 8 + N_DIG;
    localparam int FIRST_STCP = SCAN_MAX + 1 + 2 * SHCP_DIV * FRAME_W;

    logic                 sys_clk;
    logic                 sys_rst_n;
    logic [4*N_DIG-1:0]   data;
    logic [N_DIG-1:0]     point;
    logic                 seg_en;
    logic                 blank_lead;
    logic                 shcp;
    logic                 stcp;
    logic                 ds;
    logic                 oe;

    seg_595_dynamic #(
        .N_DIG    (N_DIG),
        .SCAN_MAX (SCAN_MAX),
        .SHCP_DIV (SHCP_DIV)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .data       (data),
        .point      (point),
        .seg_en     (seg_en),
        .blank_lead (blank_lead),
        .shcp       (shcp),
        .stcp       (stcp),
        .ds         (ds),
        .oe         (oe)
    );

    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic [13:0] f;
        int          e;
        int          t;
    } rec_t;

    rec_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc;
    int          edges = 0;
    int          sh_total = 0;
    logic [13:0] sh = '0;
    logic        pshcp = 1'b0;
    logic        pstcp = 1'b0;

    logic [23:0] m_d;
    logic [5:0]  m_p;
    logic        m_en;
    logic        m_bl;
    int          prev_t = 0;
    bit          have_prev = 0;
    int          last_t = 0;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    // Observe the 595 pins the way the chip would: shift on shcp rise,
    // capture the whole frame on stcp rise.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            q.delete();
            edges    = 0;
            sh_total = 0;
            sh       = '0;
            pshcp    = 1'b0;
            pstcp    = 1'b0;
        end else begin
            if (shcp && !pshcp) begin
                sh = {sh[12:0], ds};
                edges++;
                sh_total++;
            end
            if (stcp && !pstcp) begin
                q.push_back('{f: sh, e: edges, t: cyc});
                edges = 0;
            end
            pshcp = shcp;
            pstcp = stcp;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [13:0] model(input int dig, input logic [23:0] d,
                                          input logic [5:0] p, input logic en, input logic bl);
        logic [23:0] upper;
        logic [7:0]  s;
        logic [5:0]  sel;
        upper = d >> (4 * dig);
        if (!en || (bl && dig != 0 && upper == 24'h0)) s = 8'hFF;
        else                                            s = hex7(upper[3:0]);
        if (p[dig]) s = s & 8'h7F;
        sel = 6'b000001 << dig;
        return {sel, s};
    endfunction

    task automatic get_frame(output rec_t r);
        bit got;
        got = 0;
        r.f = 'x;
        r.e = -1;
        r.t = -1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge sys_clk);
            #1;
            if (q.size() > 0) begin
                r   = q.pop_front();
                got = 1;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $error("FAIL frame_timeout: observed=none expected=stcp rise within 400 cycles");
        end
    endtask

    task automatic wait_mid_shift();
        for (int i = 0; i < 200; i++) begin
            @(posedge sys_clk);
            #1;
            if (edges >= 4) return;
        end
        total++;
        bad++;
        $error("FAIL shift_timeout: observed=no shifting expected=frame in progress");
    endtask

    // Only called while the next frame to be loaded is digit 0.
    task automatic apply(input logic [23:0] d, input logic [5:0] p, input logic en, input logic bl);
        data = d;  point = p;  seg_en = en;  blank_lead = bl;
        m_d  = d;  m_p   = p;  m_en   = en;  m_bl       = bl;
    endtask

    task automatic expect_frame(input int dig, input string tag);
        rec_t r;
        get_frame(r);
        chk($sformatf("%s_d%0d_frame", tag, dig), 32'(r.f), 32'(model(dig, m_d, m_p, m_en, m_bl)));
        chk($sformatf("%s_d%0d_shcp_edges", tag, dig), 32'(r.e), 32'(FRAME_W));
        if (have_prev) chk($sformatf("%s_d%0d_slot", tag, dig), 32'(r.t - prev_t), 32'(SCAN_MAX));
        prev_t    = r.t;
        have_prev = 1;
        last_t    = r.t;
    endtask

    // mode 0: inputs untouched; 1: random inputs mid-refresh; 2: seg_en drops mid-frame.
    task automatic refresh(input int mode, input string tag);
        for (int dig = 0; dig < N_DIG; dig++) begin
            expect_frame(dig, tag);
            if (mode == 1 && dig == 0) begin
                wait_mid_shift();
                data       = 24'($urandom);
                point      = 6'($urandom);
                seg_en     = 1'($urandom);
                blank_lead = 1'($urandom);
            end
            if (mode == 2 && dig == 2) begin
                wait_mid_shift();
                seg_en = 1'b0;
            end
        end
    endtask

    task automatic first_frame_after_reset(input string tag);
        expect_frame(0, tag);
        chk({tag, "_latency"}, 32'(last_t), 32'(FIRST_STCP));
        chk({tag, "_oe_before_latch_end"}, 32'(oe), 32'd1);
        @(posedge sys_clk);
        #1;
        chk({tag, "_oe_after_latch"}, 32'(oe), 32'd0);
        for (int dig = 1; dig < N_DIG; dig++) expect_frame(dig, tag);
    endtask

    initial begin
        logic [23:0] mask;
        logic [23:0] rd;
        int          nz;
        bit          found;

        sys_rst_n = 1'b0;
        apply(24'h123456, 6'b000000, 1'b1, 1'b0);

        // T1: reset values
        #40;
        chk("rst_shcp", 32'(shcp), 32'd0);
        chk("rst_stcp", 32'(stcp), 32'd0);
        chk("rst_ds",   32'(ds),   32'd0);
        chk("rst_oe",   32'(oe),   32'd1);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (SCAN_MAX - 5) @(posedge sys_clk);
        #1;
        chk("no_shcp_before_tick", 32'(sh_total), 32'd0);
        chk("oe_before_first_latch", 32'(oe), 32'd1);

        // T2/T3: first refresh of 123456, digit 0 frame is 0x0182
        first_frame_after_reset("t2");

        // Wrap back to digit 0, inputs perturbed mid-refresh
        apply(24'h123456, 6'b010101, 1'b1, 1'b0);
        refresh(1, "t3");

        // T4: leading-zero blanking with a dp on a blanked digit
        apply(24'h000070, 6'b100000, 1'b1, 1'b1);
        refresh(0, "t4");

        // T5: seg_en drops mid-frame; takes effect on the next refresh only
        apply(24'h123456, 6'b000000, 1'b1, 1'b1);
        refresh(2, "t5a");
        apply(24'h123456, 6'b000000, 1'b0, 1'b1);
        refresh(0, "t5b");

        // Random refreshes with random leading-zero runs
        for (int k = 0; k < 4; k++) begin
            nz   = $urandom_range(0, 6);
            mask = 24'hFFFFFF;
            mask = mask >> (4 * nz);
            rd   = 24'($urandom) & mask;
            apply(rd, 6'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
            refresh(1, $sformatf("rnd%0d", k));
        end

        // T6: reset in the middle of a shift
        apply(24'($urandom), 6'($urandom), 1'b1, 1'b0);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge sys_clk);
            #1;
            if (shcp === 1'b1 && ds === 1'b1) found = 1;
        end
        if (!found) begin
            total++;
            bad++;
            $error("FAIL t6_no_shift: observed=no shcp high with ds high expected=frame in progress");
        end
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk("t6_shcp", 32'(shcp), 32'd0);
        chk("t6_stcp", 32'(stcp), 32'd0);
        chk("t6_ds",   32'(ds),   32'd0);
        chk("t6_oe",   32'(oe),   32'd1);
        have_prev = 0;
        apply(24'h0F00A0, 6'b000011, 1'b1, 1'b1);
        #40;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
        chk("t6_oe_after_release", 32'(oe), 32'd1);
        first_frame_after_reset("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
